fifo_eth_rd_stream: RTL and testbench
=====================================

# fifo_eth_rd_stream

Read-side adapter placed directly downstream of the 8-to-32-bit Ethernet byte FIFO. It drives the FIFO's standard (non-first-word-fall-through) read port, absorbs the one-cycle read latency in a 3-entry skid buffer, and presents a valid/ready 32-bit word stream. Packets are fixed-length, and the adapter marks each one with start-of-frame and end-of-frame flags. It runs entirely in the FIFO read clock domain.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; equals the FIFO read width.
- PKT_WORDS, 16, words per packet; legal range 1..65535.
- CNT_WIDTH, 16, width of `word_idx` and the statistics counters.

Ports:
- rd_clk  in  1  read-domain clock, shared with the FIFO read port.
- rd_rst_n  in  1  synchronous, active-low reset.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data; valid in the cycle after `fifo_rd_en`.
- fifo_rd_empty  in  1  FIFO empty flag.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  output word.
- m_sof  out  1  current word is the first of a packet.
- m_eof  out  1  current word is the last of a packet.
- word_idx  out  CNT_WIDTH  index of the current word within its packet.
- stall_cnt  out  CNT_WIDTH  mid-packet starvation cycles (see Configuration).
- pkt_cnt  out  CNT_WIDTH  completed packets (see Configuration).

## Operation
- State held:
  - `occ` (0..3): buffer occupancy.
  - `inflight` (0/1): a FIFO read has been issued and its data has not yet arrived.
  - 3-entry circular buffer with write pointer `wp` and read pointer `rp`, both 2-bit, wrapping 2→0.
  - `word_idx`.
- `fifo_rd_en = rd_rst_n & ~fifo_rd_empty & (occ + inflight < 3)`.
  - Depends only on registered state and `fifo_rd_empty`.
  - No combinational path from `m_ready`.
- `inflight` is the registered value of `fifo_rd_en`.
- When `inflight` = 1, `fifo_rd_data` is written to `buf[wp]` and `wp` advances.
- Pop: `m_valid & m_ready` advances `rp`.
- `occ` update:
  - increments on a write without a pop;
  - decrements on a pop without a write;
  - is unchanged when a write and a pop occur together.
- `m_valid = (occ != 0)`; `m_data = buf[rp]`.
- `m_data` holds steady while `m_valid & ~m_ready`.
- `word_idx`:
  - advances on each pop;
  - wraps PKT_WORDS-1 → 0;
  - with PKT_WORDS = 1, stays at 0.
- `m_sof = m_valid & (word_idx == 0)`.
- `m_eof = m_valid & (word_idx == PKT_WORDS-1)`.
- Boundary conditions:
  - FIFO empty: no reads are issued; buffered words still drain.
  - Buffer full (`occ + inflight == 3`): reads stop, which gives backpressure to the FIFO.
  - Data never overflows the buffer. An invariant check asserts `occ + inflight <= 3`.
- Reset (rd_rst_n = 0 at a rising edge):
  - `occ`, `inflight`, `wp`, `rp`, `word_idx` and both counters clear to 0.
  - Any read in flight is discarded.
  - `fifo_rd_en` is forced to 0 while reset is low.
- Reset values of outputs: `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `m_sof` 0, `m_eof` 0, `word_idx` 0, `stall_cnt` 0, `pkt_cnt` 0.
- Reset is expected to be asserted together with the FIFO `rd_rst`. A reset in mid-packet restarts packet alignment at `word_idx` 0.

## Timing
- Read latency:
  - `fifo_rd_en` high in cycle N → data in `fifo_rd_data` in cycle N+1.
  - Data is captured at the end of cycle N+1.
  - `m_valid` is high from cycle N+2.
- First word: if the FIFO becomes non-empty in cycle N with the buffer empty, `m_valid` rises in cycle N+2.
- Sustained throughput is 1 word per cycle while the FIFO is non-empty and `m_ready` = 1.
- Backpressure: after `m_ready` falls, at most 1 further FIFO read completes before reads stop.
- All outputs are registered, or decoded from registered state, with no path from `m_ready`. The exception is `fifo_rd_en`, which also depends on `fifo_rd_empty`.

## Configuration
- Macro: `FIFO_ETH_RD_STATS_EN`.
- Defined:
  - `stall_cnt` increments, saturating at all-ones, in each cycle with `m_ready & ~m_valid & (word_idx != 0)`.
  - `pkt_cnt` increments, wrapping, on each pop with `m_eof`.
- Undefined: the counters are not built, and both ports are tied to 0.

## Test plan
- Reset then idle: hold rd_rst_n = 0 for 3 cycles with the FIFO empty → all outputs 0 and `fifo_rd_en` never asserted.
- Single word: FIFO goes non-empty with 0xDEADBEEF, `m_ready` = 1:
  - `fifo_rd_en` 1 cycle;
  - `m_valid` two cycles later with `m_data` = 0xDEADBEEF;
  - `m_sof` = 1, `word_idx` = 0.
- Streaming: FIFO preloaded with 32 words 0..31, PKT_WORDS = 16, `m_ready` = 1:
  - 32 consecutive valid cycles;
  - `m_sof` on words 0 and 16, `m_eof` on words 15 and 31;
  - `pkt_cnt` = 2 when stats are enabled.
- Backpressure: `m_ready` = 0 for 10 cycles during a stream → at most 3 words buffered, `fifo_rd_en` deasserted, `m_data` stable; no word lost or duplicated after release.
- Starvation: FIFO empties after word 5 of a packet for 7 cycles while `m_ready` = 1 → `m_valid` 0 for those cycles, `stall_cnt` = 7 (stats on) or 0 (stats off), `word_idx` resumes at 6.
- Mid-packet reset: assert rd_rst_n = 0 while `inflight` = 1 and `occ` = 2 → next cycle `m_valid` = 0 and `word_idx` = 0; the discarded read never appears on `m_data`.

Source files
------------

// File: rtl/fifo_eth_rd_stream.sv
// Read-side adapter for the Ethernet byte FIFO: 3-entry skid buffer, valid/ready stream, SOF/EOF framing.
// Optional stall/packet counters are built when FIFO_ETH_RD_STATS_EN is defined.
module fifo_eth_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_WORDS  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic [CNT_WIDTH-1:0]  word_idx,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PKT_WORDS - 1);

    logic [DATA_WIDTH-1:0] mem [3];
    logic [1:0]            occ;
    logic [1:0]            wp;
    logic [1:0]            rp;
    logic                  inflight;
    logic [2:0]            level;
    logic                  pop;

    // Count the outstanding read so the buffer can never be overrun.
    assign level      = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en = rd_rst_n & ~fifo_rd_empty & (level < 3'd3);
    assign m_valid    = (occ != 2'd0);
    assign m_data     = mem[rp];
    assign pop        = m_valid & m_ready;
    assign m_sof      = m_valid & (word_idx == '0);
    assign m_eof      = m_valid & (word_idx == LAST_IDX);

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            occ      <= '0;
            inflight <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            word_idx <= '0;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            assert (level <= 3'd3);
            inflight <= fifo_rd_en;
            if (inflight) begin
                mem[wp] <= fifo_rd_data;
                wp      <= ptr_next(wp);
            end
            if (pop) begin
                rp       <= ptr_next(rp);
                word_idx <= (word_idx == LAST_IDX) ? '0
                                                   : word_idx + CNT_WIDTH'(1);
            end
            unique case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_ETH_RD_STATS_EN
    // Starvation only counts inside a packet; idle gaps between packets are free.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            stall_cnt <= '0;
            pkt_cnt   <= '0;
        end else begin
            if (m_ready & ~m_valid & (word_idx != '0) & (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (pop & m_eof) begin
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign pkt_cnt   = '0;
`endif

endmodule

// File: tb/tb_fifo_eth_rd_stream.sv
// Directed bench for fifo_eth_rd_stream with a behavioural standard-read FIFO.
// Expectations for the counters follow FIFO_ETH_RD_STATS_EN.
module tb_fifo_eth_rd_stream;

`ifdef FIFO_ETH_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        rd_clk = 1'b0;
    logic        rd_rst_n = 1'b0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_rd_empty = 1'b1;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_sof;
    logic        m_eof;
    logic [15:0] word_idx;
    logic [15:0] stall_cnt;
    logic [15:0] pkt_cnt;

    logic [31:0] q[$];
    logic [31:0] rx[$];
    int          nrd = 0;
    logic        pend;
    int          nvec = 0;
    int          nerr = 0;

    fifo_eth_rd_stream #(
        .DATA_WIDTH(32),
        .PKT_WORDS (16),
        .CNT_WIDTH (16)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_sof        (m_sof),
        .m_eof        (m_eof),
        .word_idx     (word_idx),
        .stall_cnt    (stall_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // Standard-read FIFO: data appears the cycle after the strobe.
    always @(posedge rd_clk) begin
        pend = fifo_rd_en;
        #1;
        if (pend && q.size() > 0) begin
            fifo_rd_data = q.pop_front();
            nrd++;
        end
        fifo_rd_empty = (q.size() == 0);
    end

    always @(posedge rd_clk) begin
        if (rd_rst_n && m_valid && m_ready) rx.push_back(m_data);
    end

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        fifo_rd_empty = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b0;
        m_ready  = 1'b0;
        repeat (2) @(posedge rd_clk);
        #1;
        q.delete();
        rx.delete();
        nrd = 0;
        fifo_rd_empty = 1'b1;
    endtask

    task automatic release_reset();
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [83:0] obs;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            obs = {fifo_rd_en, m_valid, m_data, m_sof, m_eof,
                   word_idx, stall_cnt, pkt_cnt};
            nvec++;
            if (obs !== '0) begin
                nerr++;
                $display("FAIL reset_outputs cyc %0d: got %h want 0", i, obs);
            end
        end
        push(32'h1234_5678);
        for (int i = 0; i < 2; i++) begin
            @(negedge rd_clk);
            nvec++;
            if (fifo_rd_en !== 1'b0) begin
                nerr++;
                $display("FAIL reset_rd_en_forced: got %b want 0", fifo_rd_en);
            end
        end
    endtask

    task automatic test_single();
        apply_reset();
        m_ready = 1'b1;
        release_reset();
        @(negedge rd_clk);
        nvec++;
        if ({fifo_rd_en, m_valid} !== 2'b00) begin
            nerr++;
            $display("FAIL single_idle: got %b want 00", {fifo_rd_en, m_valid});
        end
        @(posedge rd_clk);
        #1;
        push(32'hDEAD_BEEF);
        @(negedge rd_clk);
        nvec++;
        if ({fifo_rd_en, m_valid} !== 2'b10) begin
            nerr++;
            $display("FAIL single_n0: got %b want 10", {fifo_rd_en, m_valid});
        end
        @(negedge rd_clk);
        nvec++;
        if ({fifo_rd_en, m_valid} !== 2'b00) begin
            nerr++;
            $display("FAIL single_n1: got %b want 00", {fifo_rd_en, m_valid});
        end
        @(negedge rd_clk);
        nvec++;
        if ({m_valid, m_data, m_sof, m_eof, word_idx} !==
            {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'd0}) begin
            nerr++;
            $display("FAIL single_n2: got v=%b d=%h sof=%b eof=%b idx=%0d want v=1 d=deadbeef sof=1 eof=0 idx=0",
                     m_valid, m_data, m_sof, m_eof, word_idx);
        end
        @(negedge rd_clk);
        nvec++;
        if ({m_valid, word_idx} !== {1'b0, 16'd1}) begin
            nerr++;
            $display("FAIL single_after: got v=%b idx=%0d want v=0 idx=1", m_valid, word_idx);
        end
    endtask

    task automatic test_stream();
        int k = 0;
        int first = -1;
        int last = -1;
        logic [49:0] obs;
        logic [49:0] exp;
        apply_reset();
        for (int i = 0; i < 32; i++) push(32'(i));
        m_ready = 1'b1;
        release_reset();
        for (int c = 0; c < 60 && k < 32; c++) begin
            @(negedge rd_clk);
            if (m_valid) begin
                if (first < 0) first = c;
                last = c;
                obs = {m_data, m_sof, m_eof, word_idx};
                exp = {32'(k), (k % 16) == 0, (k % 16) == 15, 16'(k % 16)};
                nvec++;
                if (obs !== exp) begin
                    nerr++;
                    $display("FAIL stream_word %0d: got %h want %h", k, obs, exp);
                end
                k++;
            end
        end
        nvec++;
        if (k != 32 || last - first != 31) begin
            nerr++;
            $display("FAIL stream_span: got %0d words over %0d cycles want 32 over 32",
                     k, last - first + 1);
        end
        repeat (2) @(negedge rd_clk);
        nvec++;
        if (pkt_cnt !== (STATS ? 16'd2 : 16'd0)) begin
            nerr++;
            $display("FAIL stream_pkt_cnt: got %0d want %0d", pkt_cnt, STATS ? 2 : 0);
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        logic [31:0] held;
        apply_reset();
        for (int i = 0; i < 20; i++) push(32'(i));
        m_ready = 1'b1;
        release_reset();
        while (rx.size() < 4 && t < 40) begin
            @(negedge rd_clk);
            t++;
        end
        @(posedge rd_clk);
        #1;
        m_ready = 1'b0;
        for (int d = 0; d < 10; d++) begin
            @(negedge rd_clk);
            if (d == 0) held = m_data;
            nvec++;
            if (m_valid !== 1'b1 || m_data !== 32'(rx.size()) || m_data !== held) begin
                nerr++;
                $display("FAIL bp_hold cyc %0d: got v=%b d=%0d want v=1 d=%0d",
                         d, m_valid, m_data, rx.size());
            end
            if (d >= 2) begin
                nvec++;
                if (fifo_rd_en !== 1'b0) begin
                    nerr++;
                    $display("FAIL bp_rd_en cyc %0d: got %b want 0", d, fifo_rd_en);
                end
            end
        end
        nvec++;
        if (nrd - rx.size() != 3) begin
            nerr++;
            $display("FAIL bp_buffered: got %0d want 3", nrd - rx.size());
        end
        @(posedge rd_clk);
        #1;
        m_ready = 1'b1;
        t = 0;
        while (rx.size() < 20 && t < 80) begin
            @(negedge rd_clk);
            t++;
        end
        nvec++;
        if (rx.size() != 20) begin
            nerr++;
            $display("FAIL bp_count: got %0d want 20", rx.size());
        end
        for (int i = 0; i < rx.size() && i < 20; i++) begin
            nvec++;
            if (rx[i] !== 32'(i)) begin
                nerr++;
                $display("FAIL bp_order %0d: got %0d want %0d", i, rx[i], i);
            end
        end
    endtask

    task automatic test_starvation();
        int t = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) push(32'(i));
        m_ready = 1'b1;
        release_reset();
        while (rx.size() < 6 && t < 40) begin
            @(negedge rd_clk);
            t++;
        end
        nvec++;
        if (m_valid !== 1'b0 || word_idx !== 16'd6) begin
            nerr++;
            $display("FAIL starve_c0: got v=%b idx=%0d want v=0 idx=6", m_valid, word_idx);
        end
        for (int i = 1; i < 7; i++) begin
            @(posedge rd_clk);
            #1;
            if (i == 5) begin
                push(32'd6);
                push(32'd7);
            end
            @(negedge rd_clk);
            nvec++;
            if (m_valid !== 1'b0) begin
                nerr++;
                $display("FAIL starve_gap cyc %0d: got v=%b want 0", i, m_valid);
            end
        end
        @(negedge rd_clk);
        nvec++;
        if ({m_valid, m_data, m_sof, word_idx} !== {1'b1, 32'd6, 1'b0, 16'd6}) begin
            nerr++;
            $display("FAIL starve_resume: got v=%b d=%0d sof=%b idx=%0d want v=1 d=6 sof=0 idx=6",
                     m_valid, m_data, m_sof, word_idx);
        end
        nvec++;
        if (stall_cnt !== (STATS ? 16'd7 : 16'd0)) begin
            nerr++;
            $display("FAIL starve_stall_cnt: got %0d want %0d", stall_cnt, STATS ? 7 : 0);
        end
    endtask

    task automatic test_midreset();
        int t = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) push(32'(i));
        m_ready = 1'b0;
        release_reset();
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        nvec++;
        if ({m_valid, m_data, fifo_rd_en} !== {1'b1, 32'd0, 1'b0} || nrd != 3) begin
            nerr++;
            $display("FAIL midrst_pre: got v=%b d=%0d en=%b reads=%0d want v=1 d=0 en=0 reads=3",
                     m_valid, m_data, fifo_rd_en, nrd);
        end
        rd_rst_n = 1'b0;
        @(negedge rd_clk);
        nvec++;
        if ({m_valid, word_idx, m_data} !== {1'b0, 16'd0, 32'd0}) begin
            nerr++;
            $display("FAIL midrst_clear: got v=%b idx=%0d d=%0d want 0 0 0",
                     m_valid, word_idx, m_data);
        end
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
        m_ready  = 1'b1;
        while (!m_valid && t < 20) begin
            @(negedge rd_clk);
            t++;
        end
        nvec++;
        if ({m_valid, m_data, m_sof, word_idx} !== {1'b1, 32'd3, 1'b1, 16'd0}) begin
            nerr++;
            $display("FAIL midrst_first: got v=%b d=%0d sof=%b idx=%0d want v=1 d=3 sof=1 idx=0",
                     m_valid, m_data, m_sof, word_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_starvation();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
